// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//
// Shares one asynchronous RAM (level-sensitive write enable, combinational
// read) between two requesters, A and B. Each requester raises req with its
// operation (we, adress, WD) and holds it until ack. One winner is chosen per
// transaction. For a write, the arbiter drives the RAM pins through a
// setup/strobe/hold sequence. For a read, it captures ram_Q into that
// requester's Q register. It then returns a one-cycle ack.
//
// Every output comes straight from a flop. ram_WE in particular is a
// register output, so it cannot glitch while the address or data change.
//
// Build option:
//   RAM_ARB_RR_EN  defined   : round-robin on ties (last granted loses).
//                  undefined : fixed priority, A always wins a tie. B can be
//                              starved while a_req stays high.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   a_req/a_we/a_adress/a_WD   requester A request, op, address, write data
//   a_ack, a_Q           A completion pulse and registered read data
//   b_*                  same set for requester B
//   ram_adress, ram_WD   RAM address / write data (change only on grant)
//   ram_WE               RAM write enable, one-cycle strobe
//   ram_Q                RAM combinational read data
//   busy                 high whenever the FSM is not in IDLE
// ----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_adress,
    input  logic [DW-1:0] a_WD,
    output logic          a_ack,
    output logic [DW-1:0] a_Q,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_adress,
    input  logic [DW-1:0] b_WD,
    output logic          b_ack,
    output logic [DW-1:0] b_Q,

    output logic [AW-1:0] ram_adress,
    output logic [DW-1:0] ram_WD,
    output logic          ram_WE,
    input  logic [DW-1:0] ram_Q,

    output logic          busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] STROBE  = 3'd2;
    localparam logic [2:0] HOLD    = 3'd3;
    localparam logic [2:0] CAPTURE = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]    state_reg, state_next;
    logic          op_we_reg;     // latched operation of the current winner
    logic          win_reg;       // current winner: 0 = A, 1 = B
    logic [AW-1:0] adr_reg;
    logic [DW-1:0] wd_reg;
    logic          ram_we_reg;
    logic          busy_reg;

    logic          any_req;
    logic          grant_b;       // winner chosen when IDLE sees a request

    assign any_req = a_req | b_req;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef RAM_ARB_RR_EN
    // last_reg = 1 means B was granted last. It resets to B so that A
    // wins the first tie.
    logic last_reg;

    // On a tie, B wins only when A was the last requester served.
    assign grant_b = b_req & (~a_req | ~last_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (state_reg == IDLE && any_req) begin
            last_reg <= grant_b;
        end
    end
`else
    assign grant_b = b_req & ~a_req;
`endif

    // ------------------------------------------------------------------
    // Transaction sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = SETUP;
            SETUP:   state_next = op_we_reg ? STROBE : CAPTURE;
            STROBE:  state_next = HOLD;
            HOLD:    state_next = DONE;
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_we_reg  <= 1'b0;
            win_reg    <= 1'b0;
            adr_reg    <= '0;
            wd_reg     <= '0;
            ram_we_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Registered from the next state, so the strobe is high for
            // exactly the STROBE cycle and busy is low for exactly IDLE.
            ram_we_reg <= (state_next == STROBE);
            busy_reg   <= (state_next != IDLE);
            // Address and data are loaded only on a grant. They stay put
            // through setup, strobe and hold.
            if (state_reg == IDLE && any_req) begin
                win_reg   <= grant_b;
                op_we_reg <= grant_b ? b_we     : a_we;
                adr_reg   <= grant_b ? b_adress : a_adress;
                wd_reg    <= grant_b ? b_WD     : a_WD;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-requester ack pulse and read-data register. Port 0 is A and
    // port 1 is B. Only the current winner's registers ever change.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic          ack_reg;
            logic [DW-1:0] q_reg;
            logic          is_win;

            assign is_win = (win_reg == 1'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ack_reg <= 1'b0;
                    q_reg   <= '0;
                end else begin
                    ack_reg <= (state_next == DONE) && is_win;
                    if (state_reg == CAPTURE && is_win) begin
                        q_reg <= ram_Q;
                    end
                end
            end
        end
    endgenerate

    assign a_ack      = g_port[0].ack_reg;
    assign a_Q        = g_port[0].q_reg;
    assign b_ack      = g_port[1].ack_reg;
    assign b_Q        = g_port[1].q_reg;
    assign ram_adress = adr_reg;
    assign ram_WD     = wd_reg;
    assign ram_WE     = ram_we_reg;
    assign busy       = busy_reg;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Clocked controller that shares a single asynchronous 256x8 RAM (level-sensitive write enable, combinational read) between two requesters, A and B. Each requester issues a read or write through a req/ack handshake. The arbiter picks one winner per transaction, sequences the RAM's address, write-data and write-enable pins through a glitch-free setup/strobe/hold write pulse or a registered read capture, and returns an ack pulse and read data. It sits between the two bus masters and the RAM instance and is the only driver of the RAM pins.

## Interface
- AW, 8: address width; RAM depth is 2**AW
- DW, 8: data width

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  requester A transaction request, held until a_ack
- a_we  in  1  A: 1 = write, 0 = read; stable while a_req is high
- a_adress  in  AW  A address
- a_WD  in  DW  A write data
- a_ack  out  1  one-cycle completion pulse to A
- a_Q  out  DW  A read data, registered
- b_req, b_we, b_adress, b_WD, b_ack, b_Q: same as A, for requester B
- ram_adress  out  AW  RAM address
- ram_WD  out  DW  RAM write data
- ram_WE  out  1  RAM write enable, registered, glitch-free
- ram_Q  in  DW  RAM read data, combinational
- busy  out  1  high in every state except IDLE

## Operation
- FSM states are IDLE, SETUP, STROBE, HOLD, CAPTURE and DONE.
- **IDLE**
  - If any req is high, choose a winner and latch its we, adress and WD into the internal registers that drive ram_adress and ram_WD. Go to SETUP.
  - If no req is high, stay in IDLE.
- **SETUP:** ram_WE=0 with address and data stable. A write goes to STROBE. A read goes to CAPTURE.
- **STROBE:** ram_WE=1. Go to HOLD.
- **HOLD:** ram_WE=0 with address and data still stable. Go to DONE.
- **CAPTURE:** latch ram_Q into the winner's Q register (a_Q or b_Q). Go to DONE.
- **DONE:** assert the winner's ack for exactly one cycle. Go to IDLE.
- **Arbitration**
  - Only one requester high: it wins.
  - Both high: the requester that was not granted last wins (round-robin).
  - last_grant resets to B, so A wins the first tie.
- **Hold rules**
  - ram_adress and ram_WD change only in the IDLE→SETUP transition.
  - A loser's req keeps waiting and is not dropped.
  - Q of the non-winner is never modified.
- **Boundary conditions**
  - req deasserted mid-transaction: the transaction still completes and ack still pulses.
  - req still high after ack: a new transaction starts. This is the back-to-back case.
  - Address 0 and address 2**AW-1 are both valid; there is no wrap logic.
  - A write followed by a read of the same address returns the new data.
- **Reset (asserted at any time, including mid-STROBE)**
  - FSM goes to IDLE and ram_WE=0 immediately, asynchronously.
  - Every output goes to 0: ack, a_Q, b_Q, ram_adress, ram_WD, ram_WE, busy.
  - A write interrupted by reset leaves that RAM location undefined.

## Timing
- Cycle 0 is the cycle in which IDLE samples req high.
- **Write**
  - SETUP is cycle 1, STROBE cycle 2, HOLD cycle 3.
  - ack is high in cycle 4.
  - ram_WE is high for exactly one cycle, with one full cycle of address/data setup before it and one cycle of hold after it.
- **Read**
  - SETUP is cycle 1, CAPTURE cycle 2.
  - ack is high in cycle 3.
  - The Q register is valid from cycle 3 and holds until that port's next read completes.
- **Throughput**
  - A new transaction can be sampled in the cycle after DONE.
  - Back-to-back writes repeat every 5 cycles; back-to-back reads repeat every 4 cycles.
- busy rises in cycle 1 and falls in the cycle after DONE.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- RAM_ARB_RR_EN defined: round-robin tie-break as described in Operation.
- RAM_ARB_RR_EN undefined: fixed priority, A always wins ties, and the last_grant register is not built.
  - B can be starved while A keeps a_req high.

## Test plan
- Reset, then A writes 0x02 to address 0x01, then A reads 0x01.
  - ram_WE is high only in write cycle 2.
  - a_ack arrives in cycle 4 of the write.
  - a_Q=0x02 at the read's ack (cycle 3).
- a_req and b_req raised in the same cycle, both writing address 0x10 (A writes 0x08, B writes 0x55); both held until acked.
  - A is served first, then B.
  - A read of 0x10 afterwards returns 0x55.
  - With RAM_ARB_RR_EN undefined and a_req held high continuously, b_ack never occurs over 20 cycles.
- Back-to-back A reads of 0x00 and 0xFF (preloaded 0x11 and 0xEE).
  - a_ack pulses 4 cycles apart.
  - a_Q=0x11, then 0xEE.
  - b_Q stays 0.
- A pulses a_req for a single cycle, then drops it.
  - The full write still executes.
  - a_ack pulses once and no second transaction starts.
- rst_n asserted during STROBE.
  - ram_WE falls asynchronously and busy=0.
  - After release, a new B write/read to address 0x20 completes normally.
